// File: rtl/even_parity_serial_tx.sv
// rtl/even_parity_serial_tx.sv - framed serial transmitter: start, data LSB-first, parity, stop
// Build option: ODD_PARITY_EN selects odd parity instead of the default even parity.
module even_parity_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state;
    logic [CW-1:0]     cyc_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nxt;
    logic              par;
    logic              par_in;

`ifdef ODD_PARITY_EN
    assign par_in = ~(^data_in);
`else
    assign par_in = ^data_in;
`endif

    assign shift_nxt  = shift >> 1;
    assign data_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);

    // tx_out is loaded together with the state change so it always matches the bit being sent
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par        <= 1'b0;
            tx_out     <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == S_IDLE) begin
                tx_out  <= 1'b1;
                cyc_cnt <= '0;
                bit_cnt <= '0;
                if (data_valid) begin
                    shift  <= data_in;
                    par    <= par_in;
                    state  <= S_START;
                    tx_out <= 1'b0;
                end
            end else if (cyc_cnt != CYC_LAST) begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end else begin
                cyc_cnt <= '0;
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        tx_out  <= shift[0];
                    end
                    S_DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                            state  <= S_PARITY;
                            tx_out <= par;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            shift   <= shift_nxt;
                            tx_out  <= shift_nxt[0];
                        end
                    end
                    S_PARITY: begin
                        state  <= S_STOP;
                        tx_out <= 1'b1;
                    end
                    default: begin
                        state      <= S_IDLE;
                        tx_out     <= 1'b1;
                        frame_done <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// tb/tb_even_parity_serial_tx.sv - randomized self-checking bench with a frame-level reference model
module tb_even_parity_serial_tx;

    localparam int DW  = 4;
    localparam int CPB = 4;
    localparam int NB  = DW + 3;
    localparam int FL  = NB * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          data_ready, tx_out, busy, frame_done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // reference model: frame as a list of bit values, position counted in cycles
    bit       m_busy = 1'b0;
    bit       m_done = 1'b0;
    int       m_pos  = 0;
    logic     m_bits [NB];

    even_parity_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .tx_out(tx_out), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic ref_parity(input logic [DW-1:0] w);
        int ones = 0;
        for (int i = 0; i < DW; i++) ones += int'(w[i]);
`ifdef ODD_PARITY_EN
        return logic'((ones % 2) == 0);
`else
        return logic'((ones % 2) == 1);
`endif
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_pos  = 0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (data_valid) begin
                m_bits[0] = 1'b0;
                for (int i = 0; i < DW; i++) m_bits[1+i] = data_in[i];
                m_bits[DW+1] = ref_parity(data_in);
                m_bits[DW+2] = 1'b1;
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == FL) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_pos  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_tx", tx_out, m_busy ? m_bits[m_pos / CPB] : 1'b1);
            chk("model_busy", busy, m_busy);
            chk("model_ready", data_ready, !m_busy);
            chk("model_done", frame_done, m_done);
        end
    end

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout, got no event expected one", name);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!m_busy && !m_done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) fail_timeout("wait_idle");
    endtask

    task automatic send(input logic [DW-1:0] w, input bit keep_valid);
        bit ok = 1'b0;
        data_in    = w;
        data_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_busy && m_pos == 0) begin ok = 1'b1; break; end
        end
        if (!keep_valid) data_valid = 1'b0;
        if (!ok) fail_timeout("send_accept");
    endtask

    task automatic parity_lit(input logic [DW-1:0] w, input logic exp_par);
        wait_idle();
        send(w, 1'b0);
        repeat ((DW + 1) * CPB) @(negedge clk);
        chk("lit_parity_bit", tx_out, exp_par);
        wait_idle();
    endtask

    logic lit1 [NB];

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_tx", tx_out, 1'b1);
        chk("reset_ready", data_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", frame_done, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // hand-computed frame for 4'b1011
`ifdef ODD_PARITY_EN
        lit1 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        lit1 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
        send(4'b1011, 1'b0);
        for (int k = 1; k <= FL; k++) begin
            chk("lit_frame_tx", tx_out, lit1[(k-1) / CPB]);
            if (k == FL) chk("lit_no_early_done", frame_done, 1'b0);
            @(negedge clk);
        end
        chk("lit_done_cycle", frame_done, 1'b1);
        chk("lit_done_ready", data_ready, 1'b1);

`ifdef ODD_PARITY_EN
        parity_lit(4'b0000, 1'b1);
        parity_lit(4'b1111, 1'b1);
        parity_lit(4'b0001, 1'b0);
`else
        parity_lit(4'b0000, 1'b0);
        parity_lit(4'b1111, 1'b0);
        parity_lit(4'b0001, 1'b1);
`endif

        // back-to-back: B must start right after the single frame_done idle cycle
        wait_idle();
        send(4'b0110, 1'b1);
        data_in = 4'b1001;
        repeat (FL) @(negedge clk);
        chk("b2b_gap_tx", tx_out, 1'b1);
        chk("b2b_gap_done", frame_done, 1'b1);
        @(negedge clk);
        chk("b2b_next_start", tx_out, 1'b0);
        chk("b2b_next_busy", busy, 1'b1);
        data_valid = 1'b0;
        wait_idle();

        // reset in the middle of data bit 2
        send(4'b1101, 1'b0);
        repeat (3 * CPB + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx", tx_out, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", data_ready, 1'b1);
        repeat (FL) begin
            @(negedge clk);
            chk("abort_no_done", frame_done, 1'b0);
        end
        send(4'b0011, 1'b0);
        wait_idle();

        // data_in churns with valid held high during a frame
        send(4'b1010, 1'b1);
        repeat (FL + 3) begin
            data_in = DW'($urandom);
            @(negedge clk);
        end
        data_valid = 1'b0;
        wait_idle();

        // random words, random gaps, random valid pulses
        for (int n = 0; n < 40; n++) begin
            data_in    = DW'($urandom);
            data_valid = logic'($urandom_range(0, 1));
            repeat ($urandom_range(1, 40)) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) data_in = DW'($urandom);
            end
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        data_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
